// File: rtl/mips_pkg.sv
// Shared MIPS control definitions.
// Opcodes, funct codes, ALU encodings and controller states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } statetype_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: aluop plus funct to ALU operation.
// Shared with the single-cycle decoder.
module mc_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD:  alucontrol = ALU_ADD;
      ALUOP_SUB:  alucontrol = ALU_SUB;
      ALUOP_RSVD: alucontrol = ALU_ADD;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving
// the shared-memory datapath selects and enables.
module mc_controller
  import mips_pkg::*;
#(
  parameter bit SUPPORT_J = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal
);

  statetype_t state_q, state_d;
  aluop_t     aluop;
  logic       pcwrite;
  logic       branch;
  logic       is_mem, is_r, is_beq;
  logic       is_addi, is_j;

  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_r    = (op == OP_RTYPE);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = SUPPORT_J && (op == OP_J);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          is_mem:  state_d = S_MEMADR;
          is_r:    state_d = S_RTYPEEX;
          is_beq:  state_d = S_BEQEX;
          is_addi: state_d = S_ADDIEX;
          is_j:    state_d = S_JEX;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // state is already FETCH in reset; only kill the enables
    if (!reset) begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle model of the
// instruction sequences plus literal spot checks.
module tb_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal;
  } ov_t;

  localparam int K_RST  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_R    = 3;
  localparam int K_BEQ  = 4;
  localparam int K_ADDI = 5;
  localparam int K_J    = 6;
  localparam int K_ILL  = 7;

  typedef struct {
    int         ka;
    int         kb;
    int         c;
    logic [5:0] f;
    logic       z;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_a, op_b, funct;
  logic       zero;
  ov_t        dut_a, dut_b;
  rec_t       exp_q[$];
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  mc_controller #(.SUPPORT_J(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op_a), .funct(funct),
    .zero(zero),
    .pcen(dut_a.pcen), .memwrite(dut_a.memwrite),
    .irwrite(dut_a.irwrite), .regwrite(dut_a.regwrite),
    .iord(dut_a.iord), .memtoreg(dut_a.memtoreg),
    .regdst(dut_a.regdst), .alusrca(dut_a.alusrca),
    .alusrcb(dut_a.alusrcb), .pcsrc(dut_a.pcsrc),
    .alucontrol(dut_a.alucontrol),
    .instr_done(dut_a.instr_done), .illegal(dut_a.illegal)
  );

  mc_controller #(.SUPPORT_J(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .op(op_b), .funct(funct),
    .zero(zero),
    .pcen(dut_b.pcen), .memwrite(dut_b.memwrite),
    .irwrite(dut_b.irwrite), .regwrite(dut_b.regwrite),
    .iord(dut_b.iord), .memtoreg(dut_b.memtoreg),
    .regdst(dut_b.regdst), .alusrca(dut_b.alusrca),
    .alusrcb(dut_b.alusrcb), .pcsrc(dut_b.pcsrc),
    .alucontrol(dut_b.alucontrol),
    .instr_done(dut_b.instr_done), .illegal(dut_b.illegal)
  );

  function automatic int ilen(input int k);
    case (k)
      K_LW:             return 5;
      K_SW, K_R, K_ADDI: return 4;
      K_BEQ, K_J:       return 3;
      K_ILL:            return 2;
      default:          return 1;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // expected outputs in cycle c (0 = fetch) of an instruction of kind k
  function automatic ov_t exp_out(input int k, input int c,
                                  input logic [5:0] f,
                                  input logic z);
    ov_t o;
    o = '0;
    o.alucontrol = 3'b010;
    if (k == K_RST) begin
      o.alusrcb = 2'b01;
    end else if (c == 0) begin
      o.pcen = 1'b1;
      o.irwrite = 1'b1;
      o.alusrcb = 2'b01;
    end else if (c == 1) begin
      o.alusrcb = 2'b11;
      o.illegal = (k == K_ILL);
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (c == 2) begin
            o.alusrca = 1'b1;
            o.alusrcb = 2'b10;
          end else if (k == K_SW) begin
            o.iord = 1'b1;
            o.memwrite = 1'b1;
            o.instr_done = 1'b1;
          end else if (c == 3) begin
            o.iord = 1'b1;
          end else begin
            o.memtoreg = 1'b1;
            o.regwrite = 1'b1;
            o.instr_done = 1'b1;
          end
        end
        K_R: begin
          if (c == 2) begin
            o.alusrca = 1'b1;
            o.alucontrol = r_alu(f);
          end else begin
            o.regdst = 1'b1;
            o.regwrite = 1'b1;
            o.instr_done = 1'b1;
          end
        end
        K_BEQ: begin
          o.alusrca = 1'b1;
          o.alucontrol = 3'b110;
          o.pcsrc = 2'b01;
          o.pcen = z;
          o.instr_done = 1'b1;
        end
        K_ADDI: begin
          if (c == 2) begin
            o.alusrca = 1'b1;
            o.alusrcb = 2'b10;
          end else begin
            o.regwrite = 1'b1;
            o.instr_done = 1'b1;
          end
        end
        K_J: begin
          o.pcsrc = 2'b10;
          o.pcen = 1'b1;
          o.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  function automatic void chk(input string nm, input ov_t act,
                              input ov_t req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %05h expected %05h @%0t",
                  nm, act, req, $time);
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk($sformatf("cyc k%0d c%0d dut", r.ka, r.c), dut_a,
          exp_out(r.ka, r.c, r.f, r.z));
      chk($sformatf("cyc k%0d c%0d dut_nj", r.kb, r.c), dut_b,
          exp_out(r.kb, r.c, r.f, r.z));
    end
  end

  task automatic lit(input string nm, input ov_t act,
                     input ov_t v, input ov_t m);
    checks++;
    if ((act & m) === v) passes++;
    else $display("FAIL lit %s: got %05h expected %05h mask %05h",
                  nm, act & m, v, m);
  endtask

  task automatic run(input int ka, input int kb,
                     input logic [5:0] oa, input logic [5:0] ob,
                     input logic [5:0] f, input logic z,
                     input int lc, input ov_t lv, input ov_t lm);
    op_a = oa;
    op_b = ob;
    funct = f;
    zero = z;
    for (int c = 0; c < ilen(ka); c++) begin
      exp_q.push_back('{ka, kb, c, f, z});
      @(negedge clk);
      #1;
      if (c == lc) begin
        lit($sformatf("k%0d c%0d dut", ka, c), dut_a, lv, lm);
        if (ka == K_ILL)
          lit("illegal nj", dut_b, lv, lm);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rst_cycle();
    exp_q.push_back('{K_RST, K_RST, 0, funct, zero});
    @(negedge clk);
    #1;
    @(posedge clk);
    #2;
  endtask

  ov_t v, m, rv;

  initial begin
    reset = 1'b1;
    op_a = 6'b100011;
    op_b = 6'b100011;
    funct = 6'b0;
    zero = 1'b0;
    rv = '0;
    rv.alusrcb = 2'b01;
    rv.alucontrol = 3'b010;
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    rst_cycle();
    rst_cycle();
    reset = 1'b1;

    v = '0; m = '0; v.irwrite = 1'b1; m.irwrite = 1'b1;
    run(K_LW, K_LW, 6'b100011, 6'b100011, 6'h00, 1'b0, 0, v, m);

    v = '0; m = '0;
    v.memwrite = 1'b1; v.iord = 1'b1; v.regwrite = 1'b0;
    m.memwrite = 1'b1; m.iord = 1'b1; m.regwrite = 1'b1;
    run(K_SW, K_SW, 6'b101011, 6'b101011, 6'h00, 1'b0, 3, v, m);

    v = '0; m = '0; v.alucontrol = 3'b110; m.alucontrol = '1;
    run(K_R, K_R, 6'b000000, 6'b000000, 6'b100010, 1'b0, 2, v, m);
    v.alucontrol = 3'b111;
    run(K_R, K_R, 6'b000000, 6'b000000, 6'b101010, 1'b0, 2, v, m);
    v = '0; m = '0;
    v.regdst = 1'b1; v.regwrite = 1'b1;
    m.regdst = 1'b1; m.regwrite = 1'b1;
    run(K_R, K_R, 6'b000000, 6'b000000, 6'b100100, 1'b1, 3, v, m);
    run(K_R, K_R, 6'b000000, 6'b000000, 6'b100101, 1'b0, -1, v, m);
    run(K_R, K_R, 6'b000000, 6'b000000, 6'b000111, 1'b0, -1, v, m);

    v = '0; m = '0;
    v.pcen = 1'b1; v.pcsrc = 2'b01; v.instr_done = 1'b1;
    m.pcen = 1'b1; m.pcsrc = '1; m.instr_done = 1'b1;
    run(K_BEQ, K_BEQ, 6'b000100, 6'b000100, 6'h00, 1'b1, 2, v, m);
    v.pcen = 1'b0;
    run(K_BEQ, K_BEQ, 6'b000100, 6'b000100, 6'h00, 1'b0, 2, v, m);

    run(K_ADDI, K_ADDI, 6'b001000, 6'b001000, 6'h20, 1'b1,
        -1, v, m);

    v = '0; m = '0; v.pcsrc = 2'b10; v.pcen = 1'b1;
    m.pcsrc = '1; m.pcen = 1'b1;
    run(K_J, K_BEQ, 6'b000010, 6'b000100, 6'h00, 1'b0, 2, v, m);

    v = '0; m = '0; v.illegal = 1'b1;
    m.illegal = 1'b1; m.regwrite = 1'b1; m.memwrite = 1'b1;
    run(K_ILL, K_ILL, 6'b111111, 6'b000010, 6'h00, 1'b0, 1, v, m);
    run(K_ILL, K_ILL, 6'b010101, 6'b000010, 6'h00, 1'b1, 1, v, m);

    // abort a lw while it sits in MEMRD
    op_a = 6'b100011;
    op_b = 6'b100011;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back('{K_LW, K_LW, c, funct, zero});
      @(negedge clk);
      #1;
      if (c < 3) begin
        @(posedge clk);
        #2;
      end
    end
    reset = 1'b0;
    #1;
    lit("async reset dut", dut_a, rv, '1);
    lit("async reset dut_nj", dut_b, rv, '1);
    @(posedge clk);
    #2;
    rst_cycle();
    reset = 1'b1;
    v = '0; m = '0; v.irwrite = 1'b1; m.irwrite = 1'b1;
    run(K_LW, K_LW, 6'b100011, 6'b100011, 6'h00, 1'b0, 0, v, m);
    run(K_SW, K_SW, 6'b101011, 6'b101011, 6'h00, 1'b1, -1, v, m);

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL queue drain: %0d records left, need 0",
               exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
